// File: rtl/float16_window_3x5_gen.sv
// Raster-order float16 pixel stream to 3x5 window generator with two line buffers.
// Pixels are moved as opaque 16-bit words; a window is emitted only when fully inside the frame.
module float16_window_3x5_gen #(
  parameter int IMG_WIDTH = 64
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         de_in,
  input  logic         sof_in,
  input  logic [15:0]  data_in,
  output logic         de_out,
  output logic [239:0] win_out
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(4);

  logic [COL_W-1:0] col_r;
  logic [1:0]       row_r;
  logic [COL_W-1:0] eff_col_s;
  logic [1:0]       eff_row_s;
  logic [COL_W-1:0] col_nxt_s;
  logic [1:0]       row_nxt_s;
  logic             valid_s;
  logic [15:0]      tap1_s;
  logic [15:0]      tap2_s;
  logic [15:0]      lb1_r [IMG_WIDTH];
  logic [15:0]      lb2_r [IMG_WIDTH];
  logic [239:0]     win_r;
  logic             de_out_r;

  // Effective position of the pixel on the input, next counter values and window-valid decode
  always_comb begin
    eff_col_s = {COL_W{1'b0}};
    eff_row_s = 2'd0;
    col_nxt_s = col_r;
    row_nxt_s = row_r;
    valid_s   = 1'b0;
    if (sof_in) begin
      eff_col_s = {COL_W{1'b0}};
      eff_row_s = 2'd0;
    end else begin
      eff_col_s = col_r;
      eff_row_s = row_r;
    end
    if (eff_col_s == COL_LAST) begin
      col_nxt_s = {COL_W{1'b0}};
      row_nxt_s = (eff_row_s == 2'd2) ? 2'd2 : eff_row_s + 2'd1;
    end else begin
      col_nxt_s = eff_col_s + COL_W'(1);
      row_nxt_s = eff_row_s;
    end
    // row >= 2 hides stale line-buffer data after a restart; col >= 4 stops line-straddling windows
    valid_s = (eff_row_s >= 2'd2) && (eff_col_s >= COL_FIRST_WIN);
  end

  // Same-cycle line-buffer taps (read happens before the write at this address)
  always_comb begin
    tap1_s = lb1_r[eff_col_s];
    tap2_s = lb2_r[eff_col_s];
  end

  // Position counters advance only on an accepted pixel
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      col_r <= {COL_W{1'b0}};
      row_r <= 2'd0;
    end else if (de_in) begin
      col_r <= col_nxt_s;
      row_r <= row_nxt_s;
    end
  end

  // Line buffers cascade: LB1 holds line r-1, LB2 receives what LB1 held (line r-2)
  always_ff @(posedge clk) begin
    if (de_in) begin
      lb1_r[eff_col_s] <= data_in;
      lb2_r[eff_col_s] <= tap1_s;
    end
  end

  // Window shift registers and output strobe
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      win_r    <= 240'd0;
      de_out_r <= 1'b0;
    end else begin
      de_out_r <= de_in && valid_s;
      if (de_in) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 4; c++) begin
            win_r[16*(5*r+c) +: 16] <= win_r[16*(5*r+c+1) +: 16];
          end
        end
        win_r[16*4  +: 16] <= tap2_s;
        win_r[16*9  +: 16] <= tap1_s;
        win_r[16*14 +: 16] <= data_in;
      end
    end
  end

  assign de_out  = de_out_r;
  assign win_out = win_r;

endmodule

// File: tb/tb_float16_window_3x5_gen.sv
// Scoreboard bench for float16_window_3x5_gen: an image-array model predicts every window,
// a monitor process pops and compares on each de_out strobe.
module tb_float16_window_3x5_gen;

  typedef struct {
    int           inst;
    logic [239:0] w;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         de8, sof8, deo8;
  logic [15:0]  d8;
  logic [239:0] win8;
  logic         dek, sofk, deok;
  logic [15:0]  dk;
  logic [239:0] wink;

  int           n_checks = 0;
  int           n_fail = 0;
  exp_t         expq[$];
  int           wdt [2] = '{8, 1024};
  int           mrow [2];
  int           mcol [2];
  logic [15:0]  img [2][6][1024];
  bit           hold_valid [2];
  logic [239:0] hold_win [2];
  bit           acc_seen [2];
  int           cyc = 0;
  int           sof_cyc = 0;
  int           first_lat = 0;
  int           strobes = 0;
  logic [239:0] strobe_win [16];
  logic [239:0] last_win;

  always #5 clk = ~clk;

  float16_window_3x5_gen #(.IMG_WIDTH(8)) u_dut8 (
    .clk(clk), .rst_b(rst_b), .de_in(de8), .sof_in(sof8), .data_in(d8),
    .de_out(deo8), .win_out(win8)
  );

  float16_window_3x5_gen #(.IMG_WIDTH(1024)) u_dutk (
    .clk(clk), .rst_b(rst_b), .de_in(dek), .sof_in(sofk), .data_in(dk),
    .de_out(deok), .win_out(wink)
  );

  task automatic chk(input string name, input logic [239:0] act, input logic [239:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] el(input logic [239:0] w, input int r, input int c);
    return w[16*(5*(r-1)+(c-1)) +: 16];
  endfunction

  function automatic logic [15:0] pixval(input int i, input int r, input int c);
    if (i == 0) return 16'((r << 8) | c);
    return 16'((r << 10) | c);
  endfunction

  // Reference: store the pixel at its frame position; a window is the 3x5 block ending here
  task automatic model_accept(input int i, input bit sof, input logic [15:0] d);
    int   r, c;
    exp_t e;
    if (sof) begin
      r = 0; c = 0; sof_cyc = cyc;
    end else begin
      r = mrow[i]; c = mcol[i];
    end
    if (r <= 5) img[i][r][c] = d;
    if (r >= 2 && r <= 5 && c >= 4) begin
      e.inst = i;
      e.w = '0;
      for (int rr = 1; rr <= 3; rr++)
        for (int cc = 1; cc <= 5; cc++)
          e.w[16*(5*(rr-1)+(cc-1)) +: 16] = img[i][r-3+rr][c-5+cc];
      expq.push_back(e);
    end
    if (c == wdt[i] - 1) begin
      mcol[i] = 0; mrow[i] = r + 1;
    end else begin
      mcol[i] = c + 1; mrow[i] = r;
    end
  endtask

  task automatic drive(input int i, input bit de, input bit sof, input logic [15:0] d);
    @(negedge clk);
    #2;
    if (i == 0) begin
      de8 = de; sof8 = sof; d8 = d;
    end else begin
      dek = de; sofk = sof; dk = d;
    end
    if (de) model_accept(i, sof, d);
  endtask

  // Idle cycles carry random sof/data with de low; they must be ignored
  task automatic send(input int i, input bit sof, input logic [15:0] d, input int duty);
    while (int'($urandom_range(99)) >= duty)
      drive(i, 1'b0, 1'($urandom_range(1)), 16'($urandom));
    drive(i, 1'b1, sof, d);
  endtask

  task automatic idle(input int i, input int n);
    repeat (n) drive(i, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic send_frame(input int i, input int rows, input int duty,
                            input logic [15:0] base, input bit rnd);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < wdt[i]; c++)
        send(i, (r == 0 && c == 0), rnd ? 16'($urandom) : base + pixval(i, r, c), duty);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      acc_seen[0] = de8 && rst_b;
      acc_seen[1] = dek && rst_b;
    end
  end

  initial begin
    exp_t         e;
    logic         dv;
    logic [239:0] wv;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        dv = (i == 0) ? deo8 : deok;
        wv = (i == 0) ? win8 : wink;
        if (dv) begin
          if (expq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: inst %0d strobed with window %h, none expected", i, wv);
          end else begin
            e = expq.pop_front();
            chk("strobe_inst", 240'(i), 240'(e.inst));
            chk("window", wv, e.w);
            hold_win[i] = e.w;
            hold_valid[i] = 1'b1;
          end
          if (strobes == 0) first_lat = cyc - sof_cyc;
          if (strobes < 16) strobe_win[strobes] = wv;
          last_win = wv;
          strobes++;
        end else if (acc_seen[i]) begin
          hold_valid[i] = 1'b0;
        end else if (hold_valid[i]) begin
          chk("win_hold", wv, hold_win[i]);
        end
      end
    end
  end

  initial begin
    rst_b = 1'b0;
    de8 = 1'b0; sof8 = 1'b0; d8 = 16'h0000;
    dek = 1'b0; sofk = 1'b0; dk = 16'h0000;
    mrow = '{0, 0};
    mcol = '{0, 0};
    hold_valid = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset_de8", 240'(deo8), 240'd0);
    chk("reset_win8", win8, 240'd0);
    chk("reset_dek", 240'(deok), 240'd0);
    chk("reset_wink", wink, 240'd0);
    rst_b = 1'b1;

    // Basic gapless 4x8 frame
    strobes = 0;
    send_frame(0, 4, 100, 16'h0000, 1'b0);
    idle(0, 3);
    chk("basic_count", 240'(strobes), 240'd8);
    chk("first_latency", 240'(first_lat), 240'd21);
    chk("first_11", 240'(el(strobe_win[0], 1, 1)), 240'h0000);
    chk("first_35", 240'(el(strobe_win[0], 3, 5)), 240'h0204);
    chk("first_23", 240'(el(strobe_win[0], 2, 3)), 240'h0102);
    chk("row3_first_31", 240'(el(strobe_win[4], 3, 1)), 240'h0300);
    chk("last_35", 240'(el(last_win, 3, 5)), 240'h0307);

    // Same frame with 30% input duty
    strobes = 0;
    send_frame(0, 4, 30, 16'h0000, 1'b0);
    idle(0, 3);
    chk("gapped_count", 240'(strobes), 240'd8);
    chk("gapped_first_35", 240'(el(strobe_win[0], 3, 5)), 240'h0204);
    chk("gapped_last_35", 240'(el(last_win, 3, 5)), 240'h0307);

    // Random data, 5 lines, 50% duty
    strobes = 0;
    send_frame(0, 5, 50, 16'h0000, 1'b1);
    idle(0, 3);
    chk("random_count", 240'(strobes), 240'd12);

    // Frame A abandoned at row 2 col 5 by the sof of frame B
    strobes = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 8; c++)
        if (!(r == 2 && c >= 5)) send(0, (r == 0 && c == 0), pixval(0, r, c), 70);
    send_frame(0, 4, 100, 16'h1000, 1'b0);
    idle(0, 3);
    chk("restart_count", 240'(strobes), 240'd9);
    chk("restart_last_35", 240'(el(last_win, 3, 5)), 240'h1307);
    chk("restart_last_11", 240'(el(last_win, 1, 1)), 240'h1103);

    // Asynchronous reset while a strobe is on the outputs
    strobes = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 8; c++)
        if (!(r == 2 && c >= 6)) send(0, (r == 0 && c == 0), pixval(0, r, c), 100);
    @(negedge clk);
    #3;
    chk("pre_reset_strobes", 240'(strobes), 240'd2);
    de8 = 1'b0;
    rst_b = 1'b0;
    hold_valid[0] = 1'b0;
    #1;
    chk("midreset_de", 240'(deo8), 240'd0);
    chk("midreset_win", win8, 240'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    strobes = 0;
    send_frame(0, 4, 100, 16'h0000, 1'b0);
    idle(0, 3);
    chk("post_reset_count", 240'(strobes), 240'd8);
    chk("post_reset_latency", 240'(first_lat), 240'd21);
    chk("post_reset_last_35", 240'(el(last_win, 3, 5)), 240'h0307);

    // Maximum width, 3 lines
    strobes = 0;
    send_frame(1, 3, 100, 16'h0000, 1'b0);
    idle(1, 3);
    chk("maxw_count", 240'(strobes), 240'd1020);
    chk("maxw_last_15", 240'(el(last_win, 1, 5)), 240'h03FF);
    chk("maxw_last_35", 240'(el(last_win, 3, 5)), 240'h0BFF);

    chk("queue_empty", 240'(expq.size()), 240'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
